// File: rtl/vpu_obj_pkg.sv
// Shared constants and enumerations for the object command issuer and its
// helpers that sit in front of object_unit.
package vpu_obj_pkg;

    localparam int NUM_OBJ   = 32;
    localparam int OBJ_IDX_W = 5;

    typedef enum logic [1:0] {
        OP_RSVD   = 2'b00,
        OP_CREATE = 2'b01,
        OP_DELETE = 2'b10,
        OP_MARK   = 2'b11
    } obj_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10,
        ST_ERR   = 2'b11
    } issuer_state_e;

endpackage

// File: rtl/obj_free_finder.sv
// Lowest-free-slot priority encoder over the shadow allocation bitmap.
// A set bitmap bit means the slot is allocated.
module obj_free_finder
    import vpu_obj_pkg::*;
#(
    parameter int N = NUM_OBJ,
    parameter int W = OBJ_IDX_W
) (
    input  logic [N-1:0] bitmap,
    output logic [W-1:0] free_idx,
    output logic         free_found
);

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        // Scan downwards so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                free_idx   = W'(i);
                free_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obj_cmd_issuer.sv
// Validates decode's object commands against a shadow allocation bitmap and
// drives object_unit's single-cycle strobes plus a one-cycle response.
module obj_cmd_issuer
    import vpu_obj_pkg::*;
#(
    parameter int ISSUE_GAP = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [OBJ_IDX_W-1:0] cmd_obj_num,
    output logic                 rsp_valid,
    output logic [OBJ_IDX_W-1:0] rsp_obj_num,
    output logic                 rsp_err,
    output logic                 crt_obj,
    output logic                 del_obj,
    output logic                 ref_addr,
    output logic                 changed_in,
    output logic [OBJ_IDX_W-1:0] obj_num,
    output logic [OBJ_IDX_W:0]   obj_count
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_op/cmd_obj_num are only sampled then.
    localparam int GAP_W = (ISSUE_GAP < 2) ? 1 : $clog2(ISSUE_GAP + 1);
    localparam logic [OBJ_IDX_W:0] FULL_COUNT = (OBJ_IDX_W + 1)'(NUM_OBJ);
    localparam logic [OBJ_IDX_W:0] CNT_ONE    = (OBJ_IDX_W + 1)'(1);
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);

    issuer_state_e        state_q, state_d;
    logic [NUM_OBJ-1:0]   bitmap_q, bitmap_d;
    logic [OBJ_IDX_W:0]   count_q, count_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 ready_q, ready_d;
    logic                 crt_q, crt_d;
    logic                 del_q, del_d;
    logic                 ref_q, ref_d;
    logic                 chg_q, chg_d;
    logic [OBJ_IDX_W-1:0] obj_num_q, obj_num_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [OBJ_IDX_W-1:0] rsp_obj_num_q, rsp_obj_num_d;

    logic [OBJ_IDX_W-1:0] free_idx;
    logic                 free_found;
    obj_op_e              in_op;
    logic                 accept;
    logic                 cmd_ok;
    logic [OBJ_IDX_W-1:0] issue_idx;

    obj_free_finder #(
        .N (NUM_OBJ),
        .W (OBJ_IDX_W)
    ) u_free_finder (
        .bitmap     (bitmap_q),
        .free_idx   (free_idx),
        .free_found (free_found)
    );

    always_comb begin
        in_op     = obj_op_e'(cmd_op);
        accept    = cmd_valid && ready_q && (state_q == ST_IDLE);
        issue_idx = (in_op == OP_CREATE) ? free_idx : cmd_obj_num;
        cmd_ok    = 1'b0;
        unique case (in_op)
            OP_CREATE: cmd_ok = free_found && (count_q != FULL_COUNT);
            OP_DELETE: cmd_ok = bitmap_q[cmd_obj_num];
            OP_MARK:   cmd_ok = bitmap_q[cmd_obj_num];
            default:   cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bitmap_d      = bitmap_q;
        count_d       = count_q;
        gap_d         = gap_q;
        crt_d         = 1'b0;
        del_d         = 1'b0;
        ref_d         = 1'b0;
        chg_d         = 1'b0;
        obj_num_d     = obj_num_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_obj_num_d = rsp_obj_num_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (cmd_ok) begin
                        state_d       = ST_ISSUE;
                        obj_num_d     = issue_idx;
                        rsp_obj_num_d = issue_idx;
                        crt_d         = (in_op == OP_CREATE);
                        del_d         = (in_op == OP_DELETE);
                        ref_d         = (in_op == OP_MARK);
                        chg_d         = (in_op == OP_MARK);
                    end else begin
                        state_d       = ST_ERR;
                        rsp_err_d     = 1'b1;
                        rsp_obj_num_d = (in_op == OP_CREATE) ? '0 : cmd_obj_num;
                    end
                end
            end
            ST_ISSUE: begin
                // The strobe registers double as the record of which
                // operation is being committed to the shadow bitmap.
                if (crt_q) begin
                    bitmap_d[obj_num_q] = 1'b1;
                    count_d             = count_q + CNT_ONE;
                end
                if (del_q) begin
                    bitmap_d[obj_num_q] = 1'b0;
                    count_d             = count_q - CNT_ONE;
                end
                if (ISSUE_GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(ISSUE_GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready keeps cmd_ready low while reset is asserted and
        // for the first cycle after release.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bitmap_q      <= '0;
            count_q       <= '0;
            gap_q         <= '0;
            ready_q       <= 1'b0;
            crt_q         <= 1'b0;
            del_q         <= 1'b0;
            ref_q         <= 1'b0;
            chg_q         <= 1'b0;
            obj_num_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_obj_num_q <= '0;
        end else begin
            state_q       <= state_d;
            bitmap_q      <= bitmap_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            ready_q       <= ready_d;
            crt_q         <= crt_d;
            del_q         <= del_d;
            ref_q         <= ref_d;
            chg_q         <= chg_d;
            obj_num_q     <= obj_num_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_obj_num_q <= rsp_obj_num_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_obj_num = rsp_obj_num_q;
    assign crt_obj     = crt_q;
    assign del_obj     = del_q;
    assign ref_addr    = ref_q;
    assign changed_in  = chg_q;
    assign obj_num     = obj_num_q;
    assign obj_count   = count_q;

endmodule

// File: tb/tb_obj_cmd_issuer.sv
// Bench for obj_cmd_issuer: directed scenarios plus random command streams
// compared against a slot-array model of object allocation.
module tb_obj_cmd_issuer;
    import vpu_obj_pkg::*;

    localparam int GAP = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [OBJ_IDX_W-1:0] cmd_obj_num;
    logic                 rsp_valid;
    logic [OBJ_IDX_W-1:0] rsp_obj_num;
    logic                 rsp_err;
    logic                 crt_obj;
    logic                 del_obj;
    logic                 ref_addr;
    logic                 changed_in;
    logic [OBJ_IDX_W-1:0] obj_num;
    logic [OBJ_IDX_W:0]   obj_count;

    always #5 clk = ~clk;

    obj_cmd_issuer #(.ISSUE_GAP(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_obj_num (cmd_obj_num),
        .rsp_valid   (rsp_valid),
        .rsp_obj_num (rsp_obj_num),
        .rsp_err     (rsp_err),
        .crt_obj     (crt_obj),
        .del_obj     (del_obj),
        .ref_addr    (ref_addr),
        .changed_in  (changed_in),
        .obj_num     (obj_num),
        .obj_count   (obj_count)
    );

    // Everything seen for one command: the response/strobe cycle, the number
    // of not-ready cycles that follow, whether those cycles were quiet, and
    // the object count once the issuer is ready again.
    typedef struct packed {
        logic                 rsp_valid;
        logic                 rsp_err;
        logic [OBJ_IDX_W-1:0] rsp_obj_num;
        logic                 crt;
        logic                 del;
        logic                 refs;
        logic                 chg;
        logic [OBJ_IDX_W-1:0] obj_num;
        logic [3:0]           gap;
        logic                 clean;
        logic [OBJ_IDX_W:0]   count;
    } obs_t;

    int checks = 0;
    int passed = 0;

    bit                   model_alloc[NUM_OBJ];
    int                   model_count;
    logic [OBJ_IDX_W-1:0] model_last_num;

    function automatic void model_reset();
        for (int i = 0; i < NUM_OBJ; i++) model_alloc[i] = 1'b0;
        model_count    = 0;
        model_last_num = '0;
    endfunction

    function automatic obs_t model_step(input logic [1:0] op, input logic [OBJ_IDX_W-1:0] n);
        obs_t e;
        int   idx;
        e           = '0;
        e.rsp_valid = 1'b1;
        e.clean     = 1'b1;
        idx         = -1;
        if (op == 2'b01) begin
            for (int i = 0; i < NUM_OBJ; i++) if (!model_alloc[i] && idx < 0) idx = i;
            if (idx < 0) begin
                e.rsp_err     = 1'b1;
                e.rsp_obj_num = '0;
            end else begin
                model_alloc[idx] = 1'b1;
                model_count++;
                model_last_num   = OBJ_IDX_W'(idx);
                e.crt            = 1'b1;
                e.rsp_obj_num    = OBJ_IDX_W'(idx);
                e.gap            = 4'(GAP);
            end
        end else if (op != 2'b00 && model_alloc[n]) begin
            if (op == 2'b10) begin
                model_alloc[n] = 1'b0;
                model_count--;
                e.del = 1'b1;
            end else begin
                e.refs = 1'b1;
                e.chg  = 1'b1;
            end
            model_last_num = n;
            e.rsp_obj_num  = n;
            e.gap          = 4'(GAP);
        end else begin
            e.rsp_err     = 1'b1;
            e.rsp_obj_num = n;
        end
        e.obj_num = model_last_num;
        e.count   = (OBJ_IDX_W + 1)'(model_count);
        return e;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("rsp_v=%0b err=%0b rnum=%0d crt=%0b del=%0b ref=%0b chg=%0b num=%0d gap=%0d quiet=%0b cnt=%0d",
                         o.rsp_valid, o.rsp_err, o.rsp_obj_num, o.crt, o.del, o.refs, o.chg,
                         o.obj_num, o.gap, o.clean, o.count);
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [OBJ_IDX_W-1:0] n, output obs_t o);
        o       = '0;
        o.clean = 1'b1;
        wait_ready();
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_obj_num = n;
        @(posedge clk);
        #1;
        // Scrambled payload after accept must not affect the command.
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_obj_num = OBJ_IDX_W'($urandom);
        @(negedge clk);
        o.rsp_valid   = rsp_valid;
        o.rsp_err     = rsp_err;
        o.rsp_obj_num = rsp_obj_num;
        o.crt         = crt_obj;
        o.del         = del_obj;
        o.refs        = ref_addr;
        o.chg         = changed_in;
        o.obj_num     = obj_num;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (crt_obj || del_obj || ref_addr || changed_in || rsp_valid) o.clean = 1'b0;
            if (cmd_ready) break;
            o.gap = o.gap + 4'd1;
        end
        o.count = obj_count;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        cmd_valid   = 1'b1;
        cmd_op      = 2'b01;
        cmd_obj_num = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        all_out = 32'({cmd_ready, rsp_valid, rsp_err, rsp_obj_num, crt_obj, del_obj,
                       ref_addr, changed_in, obj_num, obj_count});
        checks++;
        if (all_out !== 32'd0) $display("FAIL reset_outputs: got %h, required 0", all_out);
        else passed++;
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, obj_count} !== {1'b1, 6'd0})
            $display("FAIL reset_release: ready=%0b count=%0d, required ready=1 count=0", cmd_ready, obj_count);
        else passed++;
    endtask

    task automatic test_create_seq();
        obs_t obs, exp;
        for (int i = 0; i < 5; i++) begin
            exp = model_step(2'b01, '0);
            send_cmd(2'b01, OBJ_IDX_W'($urandom), obs);
            checks++;
            if (obs !== exp) $display("FAIL create_%0d: got %s required %s", i, fmt(obs), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_delete_reuse();
        obs_t obs, exp;
        exp = model_step(2'b10, 5'd3);
        send_cmd(2'b10, 5'd3, obs);
        checks++;
        if (obs !== exp) $display("FAIL delete_3: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
        exp = model_step(2'b01, '0);
        send_cmd(2'b01, 5'd17, obs);
        checks++;
        if (obs !== exp) $display("FAIL reuse_3: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
    endtask

    task automatic test_delete_free();
        obs_t obs, exp;
        exp = model_step(2'b10, 5'd7);
        send_cmd(2'b10, 5'd7, obs);
        checks++;
        if (obs !== exp) $display("FAIL delete_free_7: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
        exp = model_step(2'b00, 5'd2);
        send_cmd(2'b00, 5'd2, obs);
        checks++;
        if (obs !== exp) $display("FAIL reserved_op: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
        exp = model_step(2'b11, 5'd20);
        send_cmd(2'b11, 5'd20, obs);
        checks++;
        if (obs !== exp) $display("FAIL mark_free_20: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
    endtask

    task automatic test_mark();
        obs_t obs, exp;
        exp = model_step(2'b11, 5'd0);
        send_cmd(2'b11, 5'd0, obs);
        checks++;
        if (obs !== exp) $display("FAIL mark_0: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
    endtask

    task automatic test_fill();
        obs_t obs, exp;
        do_reset();
        for (int i = 0; i < NUM_OBJ + 1; i++) begin
            exp = model_step(2'b01, '0);
            send_cmd(2'b01, OBJ_IDX_W'($urandom), obs);
            checks++;
            if (obs !== exp) $display("FAIL fill_create_%0d: got %s required %s", i, fmt(obs), fmt(exp));
            else passed++;
        end
        exp = model_step(2'b10, 5'd31);
        send_cmd(2'b10, 5'd31, obs);
        checks++;
        if (obs !== exp) $display("FAIL delete_top: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
        exp = model_step(2'b01, '0);
        send_cmd(2'b01, '0, obs);
        checks++;
        if (obs !== exp) $display("FAIL refill_top: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            exp = model_step(2'b10, OBJ_IDX_W'(i));
            send_cmd(2'b10, OBJ_IDX_W'(i), obs);
            checks++;
            if (obs !== exp) $display("FAIL drain_%0d: got %s required %s", i, fmt(obs), fmt(exp));
            else passed++;
        end
    endtask

    task automatic test_reset_in_gap();
        obs_t        obs, exp;
        logic [31:0] all_out;
        wait_ready();
        cmd_valid   = 1'b1;
        cmd_op      = 2'b01;
        cmd_obj_num = '0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        all_out = 32'({cmd_ready, rsp_valid, rsp_err, rsp_obj_num, crt_obj, del_obj,
                       ref_addr, changed_in, obj_num, obj_count});
        checks++;
        if (all_out !== 32'd0) $display("FAIL reset_in_gap: got %h, required 0", all_out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        all_out = 32'({rsp_valid, rsp_err, crt_obj, del_obj, ref_addr, changed_in, obj_count});
        checks++;
        if (all_out !== 32'd0) $display("FAIL after_release_quiet: got %h, required 0", all_out);
        else passed++;
        exp = model_step(2'b01, '0);
        send_cmd(2'b01, 5'd9, obs);
        checks++;
        if (obs !== exp) $display("FAIL create_after_reset: got %s required %s", fmt(obs), fmt(exp));
        else passed++;
    endtask

    task automatic test_random();
        obs_t                 obs, exp;
        int                   sel;
        logic [1:0]           op;
        logic [OBJ_IDX_W-1:0] n;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)     op = 2'b00;
            else if (sel < 5) op = 2'b01;
            else if (sel < 8) op = 2'b10;
            else              op = 2'b11;
            if ($urandom_range(0, 1) == 0) n = OBJ_IDX_W'($urandom_range(0, 7));
            else                           n = OBJ_IDX_W'($urandom);
            exp = model_step(op, n);
            send_cmd(op, n, obs);
            checks++;
            if (obs !== exp) $display("FAIL random_%0d op=%0d n=%0d: got %s required %s", i, op, n, fmt(obs), fmt(exp));
            else passed++;
        end
    endtask

    initial begin
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_obj_num = '0;
        model_reset();
        test_reset();
        test_create_seq();
        test_delete_reuse();
        test_delete_free();
        test_mark();
        test_fill();
        test_reset_in_gap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
